cordic_scheduler: RTL and testbench
===================================

# cordic_scheduler

Shares one `cordic_engine` among `NREQ` requesters. Each cycle a round-robin arbiter picks one requester and loads its phase/mode into a registered issue stage that honours the engine's `pop` stall. A requester-ID tag FIFO records issue order, so each in-order engine result is routed back to the requester that asked for it. The block sits between client blocks and a single `cordic_engine` instance.

## Interface
- `BW`, 32, phase/result width (matches engine `IO_BW`)
- `NREQ`, 2, number of requesters (2..8)
- `DEPTH`, 8, max in-flight operations; tag FIFO depth, power of two
- `clk` in 1: clock
- `rst_n` in 1: reset, synchronous, active-low
- `req_valid` in NREQ: request pending, one bit per requester
- `req_phase` in NREQ*BW: phases; requester i at [i*BW +: BW]
- `req_mode` in NREQ*3: modes; requester i at [i*3 +: 3], passed through opaque
- `req_ready` out NREQ: one-hot or zero; request i is accepted this cycle
- `eng_phase` out BW: to engine `phase`
- `eng_mode` out 3: to engine `mode`
- `eng_valid_in` out 1: to engine `valid_in`
- `eng_pop` in 1: engine `pop`; 1 = engine cannot accept input this cycle
- `eng_valid_out` in 1: engine `valid_out`
- `eng_result` in BW: engine `result`
- `rsp_valid` out NREQ: one-hot; result for requester i
- `rsp_result` out BW: result data, valid when any `rsp_valid` bit is set
- `busy` out 1: issue stage full or tag FIFO non-empty
- `err_orphan` out 1: sticky; an engine result arrived with an empty tag FIFO

## Operation
- **Issue stage:** holds `eng_valid_in`, `eng_phase` and `eng_mode`.
  - Engine accepts the stage on an edge where `eng_valid_in && !eng_pop`.
  - The stage can load when it is empty or is being accepted at the same edge: `load_ok = !eng_valid_in || !eng_pop`.
  - While `eng_pop` = 1, the stage contents are held unchanged.
- **Arbiter:** round-robin with pointer `last` (reset to NREQ-1, so requester 0 has top priority after reset).
  - The winner is the first i with `req_valid[i]` set, searching from `last+1` modulo NREQ.
  - `req_ready[winner] = load_ok && (tag_count < DEPTH)`. All other bits are 0.
  - On accept: load the stage, push winner ID into the tag FIFO, set `last = winner`.
  - `last` does not move when nothing is accepted.
- **Tag FIFO:** width clog2(NREQ), count 0..DEPTH.
  - Push happens on accept; pop happens on `eng_valid_out`.
  - Simultaneous push and pop leaves the count unchanged.
  - The full check uses the pre-edge count. A pop in the same cycle does not unblock a push.
- **Response:** when `eng_valid_out` = 1 and the FIFO is non-empty, the next edge registers `rsp_result = eng_result` and `rsp_valid = onehot(head tag)`, then pops the FIFO.
  - Requesters have no backpressure; `rsp_valid` is a single-cycle pulse.
- **Orphan result:** `eng_valid_out` with an empty FIFO sets `err_orphan`. The result is dropped and `rsp_valid` stays 0.
- **Reset:** applies at any edge with `rst_n` = 0 and overrides everything.
  - All outputs go to 0, the FIFO empties, and `last = NREQ-1`.
  - Operations in flight are discarded. The engine shares this reset.

## Timing
- Request to engine: request accepted at edge E0 → `eng_valid_in` = 1 after E0. Engine takes it at the first edge E ≥ E0+1 with `eng_pop` = 0.
- Engine to response: `eng_valid_out` sampled at edge R → `rsp_valid`/`rsp_result` valid for the cycle after R. Latency is 1 cycle.
- Sustained throughput with `eng_pop` = 0 and a non-full FIFO: one issue per cycle.
- `err_orphan` is cleared only by reset.
- `busy` is registered-equivalent: derived from state only, with no combinational path from inputs.

## Structure
- Package `cordic_pkg`:
  - `MODE_W` = 3
  - `DEFAULT_BW` = 32
  - function `clog2`
  - type `tag_t` sized for the maximum NREQ of 8 (3 bits)
- Sub-module `cordic_tag_fifo`: synchronous FIFO with parameters `W` and `DEPTH`.
  - Ports: push, pop, din, dout (head), count, empty, full.
  - Pointers wrap mod DEPTH.
- The top level contains the arbiter, issue stage, response register and error flag.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles with all `req_valid` = 1 → all outputs 0; first grant after release goes to requester 0.
- **Round-robin:** NREQ = 2, both requesters always valid, `eng_pop` = 0 → `req_ready` alternates 01, 10, 01, 10. A model engine with fixed latency 5 returns results tagged to requesters in issue order; `rsp_valid` matches.
- **Stall:** assert `eng_pop` for 4 cycles while stage holds phase 0x2000_0000, mode 1 → `eng_*` stays stable, `req_ready` = 0 throughout, and the engine accepts exactly once after `eng_pop` falls.
- **Full FIFO:** DEPTH = 8 with a model engine that never returns → exactly 8 accepts, then `req_ready` = 0. One `eng_valid_out` with push requested in the same cycle → no push that cycle; push succeeds the following cycle.
- **Orphan result:** `eng_valid_out` = 1 with an empty FIFO → `err_orphan` = 1, `rsp_valid` stays 0, and the flag stays set until reset.
- **Reset mid-flight:** 3 operations outstanding, pulse `rst_n` low for 1 cycle → FIFO empty, `busy` = 0, arbiter pointer back to NREQ-1.

Source files
------------

// File: rtl/cordic_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared constants, tag type and helper function for the
//                CORDIC engine scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam int MODE_W     = 3;
    localparam int DEFAULT_BW = 32;
    localparam int MAX_NREQ   = 8;

    // Requester ID tag, wide enough for the largest supported requester count
    typedef logic [2:0] tag_t;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(8) = 3
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_scheduler_if
//  Description : Requester, engine and status signals of the CORDIC
//                scheduler. The master modport is the scheduler's view;
//                the slave modport is the surrounding clients and engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cordic_scheduler_if
    import cordic_pkg::*;
#(
    parameter int BW   = DEFAULT_BW,
    parameter int NREQ = 2
) ();

    // Requester side
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*BW-1:0]     req_phase;
    logic [NREQ*MODE_W-1:0] req_mode;
    logic [NREQ-1:0]        req_ready;

    // Engine side
    logic [BW-1:0]          eng_phase;
    logic [MODE_W-1:0]      eng_mode;
    logic                   eng_valid_in;
    logic                   eng_pop;
    logic                   eng_valid_out;
    logic [BW-1:0]          eng_result;

    // Response and status
    logic [NREQ-1:0]        rsp_valid;
    logic [BW-1:0]          rsp_result;
    logic                   busy;
    logic                   err_orphan;

    modport master (
        input  req_valid, req_phase, req_mode,
        input  eng_pop, eng_valid_out, eng_result,
        output req_ready,
        output eng_phase, eng_mode, eng_valid_in,
        output rsp_valid, rsp_result, busy, err_orphan
    );

    modport slave (
        output req_valid, req_phase, req_mode,
        output eng_pop, eng_valid_out, eng_result,
        input  req_ready,
        input  eng_phase, eng_mode, eng_valid_in,
        input  rsp_valid, rsp_result, busy, err_orphan
    );

endinterface
`default_nettype wire

// File: rtl/cordic_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_tag_fifo
//  Description : Synchronous FIFO holding the requester ID of every
//                operation issued to the engine, in issue order. The head
//                entry names the owner of the next engine result.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_tag_fifo
    import cordic_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  push,
    input  wire logic                  pop,
    input  wire logic [W-1:0]          din,
    output logic      [W-1:0]          dout,
    output logic      [clog2(DEPTH):0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int c_PTR_W = clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [W-1:0]       mem_q [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == c_CNT_W'(DEPTH));
    assign count     = count_q;
    assign dout      = mem_q[rd_ptr_q];
    // Overflow/underflow requests are ignored so the pointers stay coherent
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Next pointers and occupancy; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_scheduler
//  Description : Shares one cordic_engine between NREQ requesters. A
//                round-robin arbiter feeds a registered issue stage that
//                obeys the engine's pop stall; a tag FIFO routes each
//                in-order engine result back to the requester that asked.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_scheduler
    import cordic_pkg::*;
#(
    parameter int BW    = DEFAULT_BW,
    parameter int NREQ  = 2,
    parameter int DEPTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    cordic_scheduler_if.master bus
);

    localparam int                 c_TAG_W    = clog2(NREQ);
    localparam int                 c_CNT_W    = clog2(DEPTH) + 1;
    localparam logic [c_TAG_W-1:0] c_LAST_RST = c_TAG_W'(NREQ - 1);

    // Issue stage
    logic               stage_valid_q, stage_valid_d;
    logic [BW-1:0]      stage_phase_q, stage_phase_d;
    logic [MODE_W-1:0]  stage_mode_q,  stage_mode_d;

    // Arbiter pointer: ID of the most recent winner
    logic [c_TAG_W-1:0] last_q, last_d;

    // Response register and error flag
    logic [NREQ-1:0]    rsp_valid_q,  rsp_valid_d;
    logic [BW-1:0]      rsp_result_q, rsp_result_d;
    logic               err_orphan_q, err_orphan_d;

    logic               w_load_ok;
    logic               w_found;
    logic [c_TAG_W-1:0] w_winner;
    int                 w_dist;
    int                 w_best;
    logic               w_accept;
    logic [NREQ-1:0]    w_ready;
    logic               w_rsp_fire;
    logic [c_TAG_W-1:0] w_head;
    logic [c_CNT_W-1:0] w_count;
    logic               w_fifo_empty;
    logic               w_fifo_full;

    // The stage may take new work if it is empty or leaves at this edge
    assign w_load_ok = !stage_valid_q || !bus.eng_pop;

    // Round-robin search: nearest valid requester after last_q, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_best   = NREQ;
        w_dist   = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = i - int'(last_q) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + NREQ;
            end
            if (bus.req_valid[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_found  = 1'b1;
                w_winner = c_TAG_W'(i);
            end
        end
    end

    // Full test uses the pre-edge count, so a same-cycle pop never frees a slot
    assign w_accept = rst_n && w_found && w_load_ok && !w_fifo_full;
    assign w_ready  = w_accept ? (NREQ'(1) << w_winner) : '0;

    // Issue stage: load on accept, drain when taken, hold under pop stall
    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_phase_d = stage_phase_q;
        stage_mode_d  = stage_mode_q;
        last_d        = last_q;
        if (w_accept) begin
            stage_valid_d = 1'b1;
            last_d        = w_winner;
            for (int i = 0; i < NREQ; i++) begin
                if (w_winner == c_TAG_W'(i)) begin
                    stage_phase_d = bus.req_phase[i*BW +: BW];
                    stage_mode_d  = bus.req_mode[i*MODE_W +: MODE_W];
                end
            end
        end else if (w_load_ok) begin
            stage_valid_d = 1'b0;
        end
    end

    // A result with no outstanding tag is dropped and flagged
    assign w_rsp_fire = bus.eng_valid_out && !w_fifo_empty;

    // Response routing and sticky orphan flag
    always_comb begin
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        err_orphan_d = err_orphan_q;
        if (w_rsp_fire) begin
            rsp_valid_d  = NREQ'(1) << w_head;
            rsp_result_d = bus.eng_result;
        end
        if (bus.eng_valid_out && w_fifo_empty) begin
            err_orphan_d = 1'b1;
        end
    end

    // State registers; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_valid_q <= 1'b0;
            stage_phase_q <= '0;
            stage_mode_q  <= '0;
            last_q        <= c_LAST_RST;
            rsp_valid_q   <= '0;
            rsp_result_q  <= '0;
            err_orphan_q  <= 1'b0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_phase_q <= stage_phase_d;
            stage_mode_q  <= stage_mode_d;
            last_q        <= last_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            err_orphan_q  <= err_orphan_d;
        end
    end

    cordic_tag_fifo #(
        .W     (c_TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_accept),
        .pop   (w_rsp_fire),
        .din   (w_winner),
        .dout  (w_head),
        .count (w_count),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    assign bus.req_ready    = w_ready;
    assign bus.eng_valid_in = stage_valid_q;
    assign bus.eng_phase    = stage_phase_q;
    assign bus.eng_mode     = stage_mode_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.err_orphan   = err_orphan_q;
    // Busy depends on registered state only
    assign bus.busy         = stage_valid_q || (w_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_cordic_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_cordic_scheduler
//  Description : Self-checking bench for cordic_scheduler with a reference
//                model, a fixed-latency engine model, a directed vector
//                table and hand-written corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_scheduler;
    import cordic_pkg::*;

    localparam int BW    = 32;
    localparam int NREQ  = 2;
    localparam int DEPTH = 8;
    localparam int LAT   = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cordic_scheduler_if #(.BW(BW), .NREQ(NREQ)) bus ();

    cordic_scheduler #(
        .BW    (BW),
        .NREQ  (NREQ),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [NREQ-1:0] rv;
        logic [NREQ-1:0] ready;
    } vec_t;
    vec_t tbl [10];

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus
    logic [BW-1:0]     ph [NREQ];
    logic [MODE_W-1:0] md [NREQ];
    logic [NREQ-1:0]   rv;
    logic              pop;
    logic              man_vo;
    logic [BW-1:0]     man_res;
    bit                eng_en;

    // Engine model pipeline
    logic              pv [LAT];
    logic [BW-1:0]     pd [LAT];
    int                eng_acc;
    int                rsp_cnt [NREQ];

    // Reference model
    int                m_last;
    int                m_tags [$];
    logic              m_sv;
    logic [BW-1:0]     m_ph;
    logic [MODE_W-1:0] m_md;
    logic [NREQ-1:0]   m_rv;
    logic [BW-1:0]     m_rr;
    logic              m_err;

    // Samples taken at the falling edge
    logic [NREQ-1:0]   s_ready;
    logic              s_ev;
    logic [BW-1:0]     s_ph;
    logic [MODE_W-1:0] s_md;
    logic              s_busy;
    logic              s_err;
    logic [NREQ-1:0]   s_rsp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_last = NREQ - 1;
        m_tags.delete();
        m_sv   = 1'b0;
        m_ph   = '0;
        m_md   = '0;
        m_rv   = '0;
        m_rr   = '0;
        m_err  = 1'b0;
    endtask

    // One clock cycle: drive, check at negedge, advance models at posedge
    task automatic cycle();
        bit                found;
        int                win;
        bit                load_ok;
        bit                acc;
        logic [NREQ-1:0]   exp_ready;
        logic [NREQ-1:0]   sh;
        logic              vo;
        logic [BW-1:0]     res;
        bit                take;
        logic [BW-1:0]     tph;
        logic [MODE_W-1:0] tmd;
        int                pre_n;

        for (int i = 0; i < NREQ; i++) begin
            bus.req_phase[i*BW +: BW]         = ph[i];
            bus.req_mode[i*MODE_W +: MODE_W] = md[i];
        end
        bus.req_valid     = rv;
        bus.eng_pop       = pop;
        vo                = eng_en ? pv[LAT-1] : man_vo;
        res               = eng_en ? pd[LAT-1] : man_res;
        bus.eng_valid_out = vo;
        bus.eng_result    = res;

        @(negedge clk);
        load_ok = !m_sv || !pop;
        found   = 1'b0;
        win     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c  = (m_last + k) % NREQ;
            sh = rv >> c;
            if (!found && sh[0]) begin
                found = 1'b1;
                win   = c;
            end
        end
        acc       = rst_n && found && load_ok && (m_tags.size() < DEPTH);
        exp_ready = acc ? (NREQ'(1) << win) : '0;

        s_ready = bus.req_ready;
        s_ev    = bus.eng_valid_in;
        s_ph    = bus.eng_phase;
        s_md    = bus.eng_mode;
        s_busy  = bus.busy;
        s_err   = bus.err_orphan;
        s_rsp   = bus.rsp_valid;
        for (int i = 0; i < NREQ; i++) begin
            if (s_rsp[i]) rsp_cnt[i]++;
        end

        chk("req_ready", 64'(s_ready), 64'(exp_ready));
        chk("eng_valid_in", 64'(s_ev), 64'(m_sv));
        if (m_sv) begin
            chk("eng_phase", 64'(s_ph), 64'(m_ph));
            chk("eng_mode", 64'(s_md), 64'(m_md));
        end
        chk("rsp_valid", 64'(s_rsp), 64'(m_rv));
        if (m_rv != '0) begin
            chk("rsp_result", 64'(bus.rsp_result), 64'(m_rr));
        end
        chk("busy", 64'(s_busy), 64'(m_sv || (m_tags.size() != 0)));
        chk("err_orphan", 64'(s_err), 64'(m_err));

        take  = rst_n && s_ev && !pop;
        if (take) eng_acc++;
        tph   = s_ph;
        tmd   = s_md;
        pre_n = m_tags.size();

        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_rv = '0;
            if (vo) begin
                if (pre_n > 0) begin
                    m_rv = NREQ'(1) << m_tags[0];
                    m_rr = res;
                    void'(m_tags.pop_front());
                end else begin
                    m_err = 1'b1;
                end
            end
            if (acc) begin
                m_tags.push_back(win);
                m_sv   = 1'b1;
                m_ph   = ph[win];
                m_md   = md[win];
                m_last = win;
            end else if (load_ok) begin
                m_sv = 1'b0;
            end
        end
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = take && eng_en;
        pd[0] = tph ^ 32'hA5A5_0000 ^ BW'(tmd);
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
        end
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        rv    = '0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{2'b11, 2'b01};
        tbl[1] = '{2'b11, 2'b10};
        tbl[2] = '{2'b01, 2'b01};
        tbl[3] = '{2'b01, 2'b01};
        tbl[4] = '{2'b10, 2'b10};
        tbl[5] = '{2'b00, 2'b00};
        tbl[6] = '{2'b11, 2'b01};
        tbl[7] = '{2'b10, 2'b10};
        tbl[8] = '{2'b11, 2'b01};
        tbl[9] = '{2'b11, 2'b00};

        rst_n   = 1'b0;
        rv      = '1;
        pop     = 1'b0;
        man_vo  = 1'b0;
        man_res = '0;
        eng_en  = 1'b0;
        eng_acc = 0;
        for (int i = 0; i < NREQ; i++) begin
            ph[i] = '0;
            md[i] = '0;
            rsp_cnt[i] = 0;
        end
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        model_reset();
        @(posedge clk);
        #1;

        // Reset held with every requester asserting
        cycle();
        cycle();
        chk("reset_ready", 64'(s_ready), 64'(0));
        chk("reset_busy", 64'(s_busy), 64'(0));
        chk("reset_valid_in", 64'(s_ev), 64'(0));
        chk("reset_rsp", 64'(s_rsp), 64'(0));
        rst_n = 1'b1;

        // Directed arbitration table, engine never returns: fills the FIFO
        for (int i = 0; i < 10; i++) begin
            rv = tbl[i].rv;
            for (int r = 0; r < NREQ; r++) begin
                ph[r] = $urandom;
                md[r] = MODE_W'($urandom_range(0, 7));
            end
            cycle();
            chk($sformatf("tbl%0d_ready", i), 64'(s_ready), 64'(tbl[i].ready));
        end

        // Full FIFO: a same-cycle pop must not unblock the push
        rv      = 2'b11;
        man_vo  = 1'b1;
        man_res = 32'hCAFE_0001;
        cycle();
        chk("full_pop_noready", 64'(s_ready), 64'(0));
        man_vo = 1'b0;
        cycle();
        chk("full_next_ready", 64'(s_ready), 64'(2'b10));
        chk("full_rsp_head", 64'(s_rsp), 64'(2'b01));
        cycle();
        chk("full_again", 64'(s_ready), 64'(0));

        // Orphan result
        reset_pulse();
        rv     = '0;
        man_vo = 1'b1;
        cycle();
        man_vo = 1'b0;
        cycle();
        chk("orphan_set", 64'(s_err), 64'(1));
        chk("orphan_norsp", 64'(s_rsp), 64'(0));
        repeat (3) cycle();
        chk("orphan_sticky", 64'(s_err), 64'(1));
        reset_pulse();
        cycle();
        chk("orphan_cleared", 64'(s_err), 64'(0));

        // Reset with three operations in flight
        rv = 2'b01; cycle();
        rv = 2'b10; cycle();
        rv = 2'b01; cycle();
        rv = '0;    cycle();
        chk("inflight_busy", 64'(s_busy), 64'(1));
        reset_pulse();
        cycle();
        chk("postreset_busy", 64'(s_busy), 64'(0));
        rv = 2'b11;
        cycle();
        chk("postreset_ptr", 64'(s_ready), 64'(2'b01));

        // Stall: stage held unchanged while the engine pops
        reset_pulse();
        rv    = 2'b01;
        ph[0] = 32'h2000_0000;
        md[0] = 3'd1;
        cycle();
        eng_acc = 0;
        pop     = 1'b1;
        rv      = 2'b11;
        ph[0]   = 32'h1234_5678;
        md[0]   = 3'd5;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("stall%0d_ready", i), 64'(s_ready), 64'(0));
            chk($sformatf("stall%0d_phase", i), 64'(s_ph), 64'(32'h2000_0000));
            chk($sformatf("stall%0d_mode", i), 64'(s_md), 64'(1));
            chk($sformatf("stall%0d_valid", i), 64'(s_ev), 64'(1));
        end
        pop = 1'b0;
        rv  = '0;
        repeat (3) cycle();
        chk("stall_accept_once", 64'(eng_acc), 64'(1));

        // Round-robin with both requesters valid and a latency-5 engine
        reset_pulse();
        eng_en = 1'b1;
        for (int i = 0; i < NREQ; i++) rsp_cnt[i] = 0;
        rv = 2'b11;
        for (int i = 0; i < 8; i++) begin
            ph[0] = $urandom;
            ph[1] = $urandom;
            cycle();
            chk($sformatf("rr%0d_ready", i), 64'(s_ready), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
        end
        rv = '0;
        repeat (12) cycle();
        chk("rr_rsp0", 64'(rsp_cnt[0]), 64'(4));
        chk("rr_rsp1", 64'(rsp_cnt[1]), 64'(4));
        chk("rr_idle", 64'(s_busy), 64'(0));

        // Randomized traffic with random engine stalls
        for (int i = 0; i < 1500; i++) begin
            rv  = NREQ'($urandom_range(0, 3));
            pop = ($urandom_range(0, 3) == 0);
            for (int r = 0; r < NREQ; r++) begin
                ph[r] = $urandom;
                md[r] = MODE_W'($urandom_range(0, 7));
            end
            cycle();
        end
        rv  = '0;
        pop = 1'b0;
        repeat (15) cycle();
        chk("rand_drained", 64'(s_busy), 64'(0));
        chk("rand_no_orphan", 64'(s_err), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
